// File: rtl/multu_pipe.sv
// multu_pipe: pipelined unsigned multiplier with valid/ready handshakes.
//   Stage 1 captures the full 2*WIDTH product and the mode bit. The final
//   stage applies truncate/saturate and registers out_data/out_ovf, so the
//   pipeline holds exactly STAGES register stages. A single global advance
//   (adv = !out_valid || out_ready) moves every stage at once, and bubbles
//   are carried through rather than compressed.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          operand beat handshake (in_ready = adv)
//   in_a, in_b [WIDTH]         unsigned operands
//   in_mode                    0 = truncate, 1 = saturate
//   out_valid/out_ready        result beat handshake
//   out_data [WIDTH], out_ovf  result and "upper product bits nonzero"
//   ovf_clr                    synchronous clear of ovf_cnt (wins over increment)
//   ovf_cnt [16]               saturating count of delivered overflowed results
module multu_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  input  logic             ovf_clr,
  output logic [15:0]      ovf_cnt
);
  localparam int PW = 2 * WIDTH;

  typedef struct packed {
    logic          mode;
    logic [PW-1:0] prod;
  } stg_t;

  logic             w_adv;
  stg_t             w_in;
  stg_t             w_fin;
  logic             w_fin_vld;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res;

  logic             r_out_vld;
  logic [WIDTH-1:0] r_data;
  logic             r_ovf;
  logic [15:0]      r_cnt;

  assign w_adv    = !r_out_vld || out_ready;
  assign in_ready = w_adv;

  assign w_in.mode = in_mode;
  assign w_in.prod = PW'(in_a) * PW'(in_b);

  // With one stage the formatter feeds straight from the operands;
  // otherwise stages 1..STAGES-1 carry the raw product and mode.
  generate
    if (STAGES == 1) begin : g_direct
      assign w_fin     = w_in;
      assign w_fin_vld = in_valid;
    end else begin : g_pipe
      stg_t               r_stg [1:STAGES-1];
      logic [STAGES-1:1]  r_vld;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld <= '0;
          for (int k = 1; k < STAGES; k++) r_stg[k] <= '0;
        end else if (w_adv) begin
          r_vld[1] <= in_valid;
          // Data only loads behind a valid beat, so bubbles leave it untouched.
          if (in_valid) r_stg[1] <= w_in;
          for (int k = 2; k < STAGES; k++) begin
            r_vld[k] <= r_vld[k-1];
            if (r_vld[k-1]) r_stg[k] <= r_stg[k-1];
          end
        end
      end

      assign w_fin     = r_stg[STAGES-1];
      assign w_fin_vld = r_vld[STAGES-1];
    end
  endgenerate

  assign w_ovf = |w_fin.prod[PW-1:WIDTH];
  assign w_res = (w_fin.mode && w_ovf) ? {WIDTH{1'b1}} : w_fin.prod[WIDTH-1:0];

  // Final stage: registered result, holds its last value across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
      r_data    <= '0;
      r_ovf     <= 1'b0;
    end else if (w_adv) begin
      r_out_vld <= w_fin_vld;
      if (w_fin_vld) begin
        r_data <= w_res;
        r_ovf  <= w_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (ovf_clr)
      r_cnt <= '0;
    else if (r_out_vld && out_ready && r_ovf && (r_cnt != 16'hFFFF))
      r_cnt <= r_cnt + 16'd1;
  end

  assign out_valid = r_out_vld;
  assign out_data  = r_data;
  assign out_ovf   = r_ovf;
  assign ovf_cnt   = r_cnt;

endmodule
